// File: rtl/mod_reduce_seq_if.sv
// Valid/ready bundle between the multiplier stage and the modular reducer.
// master: product source and result consumer; slave: mod_reduce_seq.
interface mod_reduce_seq_if #(
    parameter int mul_size = 56
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2*mul_size-1:0]   dividend;
    logic [mul_size-1:0]     divisor;
    logic                    out_valid;
    logic                    out_ready;
    logic [mul_size-1:0]     quotient;
    logic [mul_size-1:0]     remainder;
    logic                    err;

    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  err
    );

    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output err
    );
endinterface

// File: rtl/mod_reduce_seq.sv
// Sequential restoring divider: 2*mul_size-bit product / mul_size-bit modulus.
// Ports: clk, rst_n (async low), bus (slave: in_valid/in_ready/dividend/divisor,
// out_valid/out_ready/quotient/remainder/err). Define RADIX4_EN for 2 steps/cycle.
module mod_reduce_seq #(
    parameter int mul_size = 56
) (
    input  logic             clk,
    input  logic             rst_n,
    mod_reduce_seq_if.slave  bus
);
    localparam int W  = mul_size;
    localparam int CW = $clog2(W + 1);

`ifdef RADIX4_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    lo_q, lo_d;
    logic [W-1:0]    dsr_q, dsr_d;
    logic [W-1:0]    r_q, r_d;
    logic [W-1:0]    q_q, q_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    rem_q, rem_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [W-1:0]    step_r;
    logic [W-1:0]    step_q;
    logic [W-1:0]    step_lo;
    logic            last;
    logic            bad_in;

    // One restoring step; returns {quotient bit, new partial remainder}.
    // t is W+1 bits wide so the shifted-out MSB of r takes part in the compare.
    function automatic logic [W:0] rstep(
        input logic [W-1:0] r,
        input logic         b,
        input logic [W-1:0] d
    );
        logic [W:0] t;
        t = {r, b};
        if (t >= {1'b0, d}) begin
            t = t - {1'b0, d};
            return {1'b1, t[W-1:0]};
        end
        return {1'b0, t[W-1:0]};
    endfunction

`ifdef RADIX4_EN
    logic [W:0] s1, s2;
    always_comb begin
        s1      = rstep(r_q, lo_q[W-1], dsr_q);
        s2      = rstep(s1[W-1:0], lo_q[W-2], dsr_q);
        step_r  = s2[W-1:0];
        step_q  = (q_q << 2) | W'({s1[W], s2[W]});
        step_lo = lo_q << 2;
        last    = (cnt_q == CW'(W - 2));
    end
`else
    logic [W:0] s1;
    always_comb begin
        s1      = rstep(r_q, lo_q[W-1], dsr_q);
        step_r  = s1[W-1:0];
        step_q  = (q_q << 1) | W'(s1[W]);
        step_lo = lo_q << 1;
        last    = (cnt_q == CW'(W - 1));
    end
`endif

    // Covers divisor==0 too: the upper half is always >= 0.
    assign bad_in = (bus.dividend[2*W-1:W] >= bus.divisor);

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        dsr_d   = dsr_q;
        r_d     = r_q;
        q_d     = q_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bad_in) begin
                        err_d   = 1'b1;
                        quo_d   = '0;
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        lo_d    = bus.dividend[W-1:0];
                        r_d     = bus.dividend[2*W-1:W];
                        dsr_d   = bus.divisor;
                        q_d     = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = step_r;
                q_d   = step_q;
                lo_d  = step_lo;
                cnt_d = cnt_q + CW'(STEP);
                if (last) begin
                    quo_d   = step_q;
                    rem_d   = step_r;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            dsr_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            dsr_q   <= dsr_d;
            r_q     <= r_d;
            q_q     <= q_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mod_reduce_seq.sv
// Random and directed bench for mod_reduce_seq against a plain-arithmetic model.
// Ports exercised through mod_reduce_seq_if; honours RADIX4_EN for latency.
module tb_mod_reduce_seq;
    localparam int M = 56;
`ifdef RADIX4_EN
    localparam int LAT = M / 2 + 1;
`else
    localparam int LAT = M + 1;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mod_reduce_seq_if #(.mul_size(M)) bus ();

    mod_reduce_seq #(.mul_size(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string        tag,
        input logic [127:0] got,
        input logic [127:0] exp
    );
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide division plus the overflow rule.
    task automatic model(
        input  logic [2*M-1:0] a,
        input  logic [M-1:0]   b,
        output logic [M-1:0]   q,
        output logic [M-1:0]   r,
        output logic           e
    );
        logic [2*M-1:0] bw;
        logic [2*M-1:0] qw;
        logic [2*M-1:0] rw;
        bw = {{M{1'b0}}, b};
        if (b == 0 || a[2*M-1:M] >= b) begin
            e = 1'b1;
            q = '0;
            r = '0;
        end else begin
            e  = 1'b0;
            qw = a / bw;
            rw = a % bw;
            q  = qw[M-1:0];
            r  = rw[M-1:0];
        end
    endtask

    function automatic logic [M-1:0] rnd56();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[M-1:0];
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge after
    // the output handshake, DUT idle again.
    task automatic run_op(
        input logic [2*M-1:0] a,
        input logic [M-1:0]   b,
        input int             hold,
        input bit             noise
    );
        logic [M-1:0] eq;
        logic [M-1:0] er;
        logic         ee;
        int           edges;
        model(a, b, eq, er, ee);
        chk("in_ready_idle", 128'(bus.in_ready), 128'(1));
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        edges = 1;
        while (!bus.out_valid && edges < 200) begin
            if (noise) begin
                bus.in_valid = 1'($urandom);
                bus.dividend = {rnd56(), rnd56()};
                bus.divisor  = rnd56();
            end
            @(negedge clk);
            edges++;
        end
        bus.in_valid = 1'b0;
        chk("latency", 128'(edges), 128'(ee ? 1 : LAT));
        chk("quotient", 128'(bus.quotient), 128'(eq));
        chk("remainder", 128'(bus.remainder), 128'(er));
        chk("err", 128'(bus.err), 128'(ee));
        chk("in_ready_busy", 128'(bus.in_ready), 128'(0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 128'(bus.out_valid), 128'(1));
            chk("hold_ready", 128'(bus.in_ready), 128'(0));
            chk("hold_q", 128'(bus.quotient), 128'(eq));
            chk("hold_r", 128'(bus.remainder), 128'(er));
            chk("hold_err", 128'(bus.err), 128'(ee));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("valid_drop", 128'(bus.out_valid), 128'(0));
        chk("ready_back", 128'(bus.in_ready), 128'(1));
    endtask

    initial begin
        logic [2*M-1:0] a;
        logic [M-1:0]   b;
        logic [M-1:0]   full;
        logic [M-1:0]   hi;
        n_cmp         = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        full          = '1;

        #1;
        chk("rst_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_q", 128'(bus.quotient), 128'(0));
        chk("rst_r", 128'(bus.remainder), 128'(0));
        chk("rst_err", 128'(bus.err), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 128'(bus.in_ready), 128'(1));

        run_op(112'd100, 56'd7, 0, 1'b0);
        a = {56'd0, full - 56'd1} * {56'd0, full - 56'd1};
        run_op(a, full, 0, 1'b0);
        run_op({rnd56(), rnd56()}, 56'd0, 0, 1'b0);
        run_op(112'd5 << 56, 56'd5, 0, 1'b0);
        run_op(112'd77777, 56'd1234, 10, 1'b0);
        run_op(112'd1000, 56'd3, 0, 1'b0);
        run_op({full - 56'd1, full}, full, 0, 1'b1);

        for (int k = 0; k < 40; k++) begin
            b = rnd56() >> $urandom_range(0, M - 1);
            if (b == 0) b = 56'd1;
            if ($urandom_range(0, 7) == 0) begin
                hi = b + (rnd56() >> $urandom_range(1, M - 1));
                if (hi < b) hi = b;
            end else begin
                hi = rnd56() % b;
            end
            a = {hi, rnd56()};
            run_op(a, b, $urandom_range(0, 3), 1'($urandom));
        end

        bus.in_valid = 1'b1;
        bus.dividend = {56'h12_3456, rnd56()};
        bus.divisor  = 56'hFF_FFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(bus.out_valid), 128'(0));
        chk("mid_rst_q", 128'(bus.quotient), 128'(0));
        chk("mid_rst_r", 128'(bus.remainder), 128'(0));
        chk("mid_rst_err", 128'(bus.err), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 128'(bus.out_valid), 128'(0));
            chk("post_rst_ready", 128'(bus.in_ready), 128'(1));
        end
        run_op(112'd100, 56'd7, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
